gp_regfile_ctx: RTL and testbench

Parametrised general-purpose register file with one shared tri-state data bus port and two ALU read ports. It adds NUM_CTX shadow context slots. A save or restore request copies the whole active bank to or from a slot, one register per clock, under a small state machine with a busy/done handshake. It sits between the data bus and the ALU in the CPU datapath and is used by the control unit for interrupt/context switching.

---
 rtl/gp_regfile_ctx_pkg.sv | 21 ++
 rtl/gp_regfile_ctx_seq.sv | 70 +++++++
 rtl/gp_regfile_ctx.sv | 87 ++++++++
 tb/tb_gp_regfile_ctx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_regfile_ctx_pkg.sv
// Shared types and sizing helpers for the context-switching register file.
package gp_regfile_ctx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } ctx_state_e;

    // Slot index is at least one bit wide even for a single context.
    function automatic int ctx_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_CTX  = 2;
    localparam int REG_IDX_W    = $clog2(DEF_NUM_REGS);
    localparam int CTX_IDX_W    = ctx_idx_w(DEF_NUM_CTX);

endpackage

// File: rtl/gp_regfile_ctx_seq.sv
// Save/restore sequencer: walks every register index once per request.
module gp_ctx_seq
    import gp_regfile_ctx_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_CTX  = DEF_NUM_CTX,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int CW       = ctx_idx_w(NUM_CTX)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_save_req,
    input  logic          i_restore_req,
    input  logic [CW-1:0] i_slot,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_copy_en,
    output logic          o_copy_dir,
    output logic [RW-1:0] o_copy_idx,
    output logic [CW-1:0] o_copy_slot
);

    ctx_state_e    r_state, w_next;
    logic [RW-1:0] r_idx;
    logic [CW-1:0] r_slot;
    logic          w_accept;
    logic          w_slot_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_slot  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx  <= '0;
                r_slot <= i_slot;
            end else if (r_state == ST_SAVE || r_state == ST_RESTORE) begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_slot_ok = (int'(i_slot) < NUM_CTX);
        case (r_state)
            ST_IDLE: begin
                if (w_slot_ok && (i_save_req || i_restore_req)) begin
                    w_accept = 1'b1;
                    w_next   = i_save_req ? ST_SAVE : ST_RESTORE;
                end
            end
            ST_SAVE, ST_RESTORE: begin
                if (r_idx == RW'(NUM_REGS - 1)) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign o_busy      = (r_state == ST_SAVE) || (r_state == ST_RESTORE);
    assign o_done      = (r_state == ST_DONE);
    assign o_copy_en   = o_busy;
    assign o_copy_dir  = (r_state == ST_RESTORE);
    assign o_copy_idx  = r_idx;
    assign o_copy_slot = r_slot;

endmodule

// File: rtl/gp_regfile_ctx.sv
// General-purpose register file with a tri-state bus port, two ALU read
// ports and shadow context slots copied one register per clock.
module gp_regfile_ctx
    import gp_regfile_ctx_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    parameter  int NUM_CTX  = 2,
    parameter  int ZERO_R0  = 0,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int CW       = ctx_idx_w(NUM_CTX)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read_data,
    input  logic              write_data,
    input  logic [RW-1:0]     input_select,
    input  logic [RW-1:0]     output_select,
    input  logic [RW-1:0]     alu_a_select,
    input  logic [RW-1:0]     alu_b_select,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic [DATA_W-1:0] alu_a_value,
    output logic [DATA_W-1:0] alu_b_value,
    input  logic              ctx_save_req,
    input  logic              ctx_restore_req,
    input  logic [CW-1:0]     ctx_slot,
    output logic              busy,
    output logic              ctx_done
);

    localparam bit ZR = (ZERO_R0 != 0);

    logic [DATA_W-1:0] r_active [NUM_REGS];
    logic [DATA_W-1:0] r_shadow [NUM_CTX][NUM_REGS];

    logic              w_copy_en;
    logic              w_copy_dir;
    logic [RW-1:0]     w_copy_idx;
    logic [CW-1:0]     w_copy_slot;
    logic              w_idle;
    logic [DATA_W-1:0] w_bus_out;

    gp_ctx_seq #(
        .NUM_REGS (NUM_REGS),
        .NUM_CTX  (NUM_CTX)
    ) u_seq (
        .i_clk         (clock),
        .i_rst         (reset),
        .i_save_req    (ctx_save_req),
        .i_restore_req (ctx_restore_req),
        .i_slot        (ctx_slot),
        .o_busy        (busy),
        .o_done        (ctx_done),
        .o_copy_en     (w_copy_en),
        .o_copy_dir    (w_copy_dir),
        .o_copy_idx    (w_copy_idx),
        .o_copy_slot   (w_copy_slot)
    );

    assign w_idle      = !busy && !ctx_done;
    assign alu_a_value = (ZR && alu_a_select  == '0) ? '0 : r_active[alu_a_select];
    assign alu_b_value = (ZR && alu_b_select  == '0) ? '0 : r_active[alu_b_select];
    assign w_bus_out   = (ZR && output_select == '0) ? '0 : r_active[output_select];
    // With read_data and write_data both set, the load captures our own drive.
    assign data_bus    = write_data ? w_bus_out : 'z;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_active[i] <= '0;
        end else if (w_copy_en && w_copy_dir) begin
            if (!(ZR && w_copy_idx == '0))
                r_active[w_copy_idx] <= r_shadow[w_copy_slot][w_copy_idx];
        end else if (w_idle && read_data && !(ZR && input_select == '0)) begin
            r_active[input_select] <= data_bus;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CTX; c++)
                for (int i = 0; i < NUM_REGS; i++) r_shadow[c][i] <= '0;
        end else if (w_copy_en && !w_copy_dir) begin
            r_shadow[w_copy_slot][w_copy_idx] <= r_active[w_copy_idx];
        end
    end

endmodule

// File: tb/tb_gp_regfile_ctx.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor checks them.
module tb_gp_regfile_ctx;

    localparam int K_A1 = 0, K_B1 = 1, K_BUS1 = 2, K_BUSZ1 = 3, K_BUSY1 = 4,
                   K_DONE1 = 5, K_DCNT1 = 6, K_A2 = 7, K_B2 = 8, K_BUSY2 = 9;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] val;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    done_cnt1 = 0;

    logic       clock = 0;
    logic       reset = 0;

    logic       rd1 = 0, wr1 = 0, sv1 = 0, rs1 = 0, slot1 = 0, drv1_en = 0;
    logic [2:0] in1 = 0, out1 = 0, a1 = 0, b1 = 0;
    logic [7:0] drv1 = 0;
    wire  [7:0] bus1;
    logic [7:0] av1, bv1;
    logic       busy1, done1;

    logic        rd2 = 0, wr2 = 0, sv2 = 0, rs2 = 0, drv2_en = 0;
    logic [1:0]  slot2 = 0;
    logic [2:0]  in2 = 0, out2 = 0, a2 = 0, b2 = 0;
    logic [15:0] drv2 = 0;
    wire  [15:0] bus2;
    logic [15:0] av2, bv2;
    logic        busy2, done2;

    assign bus1 = drv1_en ? drv1 : 'z;
    assign bus2 = drv2_en ? drv2 : 'z;

    always #5 clock = ~clock;

    gp_regfile_ctx #(.DATA_W(8), .NUM_REGS(8), .NUM_CTX(2), .ZERO_R0(0)) dut1 (
        .clock(clock), .reset(reset), .read_data(rd1), .write_data(wr1),
        .input_select(in1), .output_select(out1), .alu_a_select(a1), .alu_b_select(b1),
        .data_bus(bus1), .alu_a_value(av1), .alu_b_value(bv1),
        .ctx_save_req(sv1), .ctx_restore_req(rs1), .ctx_slot(slot1),
        .busy(busy1), .ctx_done(done1)
    );

    gp_regfile_ctx #(.DATA_W(16), .NUM_REGS(8), .NUM_CTX(3), .ZERO_R0(1)) dut2 (
        .clock(clock), .reset(reset), .read_data(rd2), .write_data(wr2),
        .input_select(in2), .output_select(out2), .alu_a_select(a2), .alu_b_select(b2),
        .data_bus(bus2), .alu_a_value(av2), .alu_b_value(bv2),
        .ctx_save_req(sv2), .ctx_restore_req(rs2), .ctx_slot(slot2),
        .busy(busy2), .ctx_done(done2)
    );

    function automatic logic [15:0] sample(input int k);
        case (k)
            K_A1:    return {8'h00, av1};
            K_B1:    return {8'h00, bv1};
            K_BUS1:  return {8'h00, bus1};
            K_BUSY1: return {15'h0, busy1};
            K_DONE1: return {15'h0, done1};
            K_DCNT1: return 16'(done_cnt1);
            K_A2:    return av2;
            K_B2:    return bv2;
            K_BUSY2: return {15'h0, busy2};
            default: return 'x;
        endcase
    endfunction

    // Monitor: the DUT outputs are sampled mid-cycle against queued expectations.
    always @(negedge clock) begin
        item_t       it;
        logic [15:0] act;
        logic        ok;
        if (done1 === 1'b1) done_cnt1++;
        while (q.size() > 0) begin
            it  = q.pop_front();
            act = sample(it.kind);
            ok  = (it.kind == K_BUSZ1) ? (bus1 === 8'hzz) : (act === it.val);
            total++;
            if (!ok) begin
                bad++;
                if (it.kind == K_BUSZ1)
                    $display("FAIL %s: got %h want zz", it.name, bus1);
                else
                    $display("FAIL %s: got %h want %h", it.name, act, it.val);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input string n, input int k, input logic [15:0] v);
        q.push_back('{n, k, v});
    endtask

    task automatic load1(input logic [2:0] idx, input logic [7:0] v);
        rd1 = 1; in1 = idx; drv1 = v; drv1_en = 1;
        step();
        rd1 = 0; drv1_en = 0;
    endtask

    task automatic load2(input logic [2:0] idx, input logic [15:0] v);
        rd2 = 1; in2 = idx; drv2 = v; drv2_en = 1;
        step();
        rd2 = 0; drv2_en = 0;
    endtask

    task automatic rdreg1(input string n, input logic [2:0] idx, input logic [7:0] v);
        a1 = idx;
        expect_v(n, K_A1, {8'h00, v});
        step();
    endtask

    task automatic copy_wait1(input string n);
        for (int c = 1; c <= 8; c++) begin
            expect_v(n, K_BUSY1, 16'd1);
            step();
        end
        expect_v(n, K_DONE1, 16'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        step();
        reset = 0;
        expect_v("rst_busy", K_BUSY1, 16'd0);
        expect_v("rst_done", K_DONE1, 16'd0);
        expect_v("rst_busz", K_BUSZ1, 16'd0);
        for (int i = 0; i < 8; i++) rdreg1("rst_reg", 3'(i), 8'h00);

        // Bus load, then drive the register back onto the bus
        load1(3'd3, 8'hA5);
        wr1 = 1; out1 = 3'd3; a1 = 3'd3;
        expect_v("drive_r3", K_BUS1, 16'h00A5);
        expect_v("alu_a_r3", K_A1,   16'h00A5);
        step();
        wr1 = 0;
        for (int i = 0; i < 8; i++)
            if (i != 3) rdreg1("others_zero", 3'(i), 8'h00);

        // Register-to-register move in one cycle
        load1(3'd1, 8'h3C);
        rd1 = 1; wr1 = 1; out1 = 3'd1; in1 = 3'd6;
        expect_v("move_bus", K_BUS1, 16'h003C);
        step();
        rd1 = 0; wr1 = 0;
        rdreg1("move_r6", 3'd6, 8'h3C);
        b1 = 3'd1;
        expect_v("move_r1_b", K_B1, 16'h003C);
        step();

        // Save slot 1, with a blocked load and an ignored request mid-copy
        for (int i = 0; i < 8; i++) load1(3'(i), 8'h10 + 8'(i));
        sv1 = 1; slot1 = 1;
        expect_v("pre_save_busy", K_BUSY1, 16'd0);
        step();
        sv1 = 0;
        for (int c = 1; c <= 8; c++) begin
            expect_v("save_busy", K_BUSY1, 16'd1);
            expect_v("save_nodone", K_DONE1, 16'd0);
            if (c == 3) begin rd1 = 1; in1 = 3'd2; drv1 = 8'h99; drv1_en = 1; end
            if (c == 5) rs1 = 1;
            step();
            rd1 = 0; drv1_en = 0; rs1 = 0;
        end
        expect_v("save_done", K_DONE1, 16'd1);
        expect_v("save_done_busy", K_BUSY1, 16'd0);
        step();
        expect_v("after_done", K_DONE1, 16'd0);
        expect_v("after_busy", K_BUSY1, 16'd0);
        expect_v("done_count_save", K_DCNT1, 16'd1);
        step();
        rdreg1("blocked_r2", 3'd2, 8'h12);

        // Clobber and restore
        for (int i = 0; i < 8; i++) load1(3'(i), 8'hFF);
        rdreg1("clobber_r3", 3'd3, 8'hFF);
        rs1 = 1; slot1 = 1;
        step();
        rs1 = 0;
        copy_wait1("restore");
        expect_v("done_count_rst", K_DCNT1, 16'd2);
        for (int i = 0; i < 8; i++) rdreg1("restored", 3'(i), 8'h10 + 8'(i));

        // Simultaneous save+restore on slot 0: save must win, regs untouched
        sv1 = 1; rs1 = 1; slot1 = 0;
        step();
        sv1 = 0; rs1 = 0;
        copy_wait1("collide");
        expect_v("done_count_col", K_DCNT1, 16'd3);
        for (int i = 0; i < 8; i++) rdreg1("collide_keep", 3'(i), 8'h10 + 8'(i));

        // Reset at copy cycle 4 of a restore
        rs1 = 1; slot1 = 1;
        step();
        rs1 = 0;
        for (int c = 1; c <= 3; c++) begin
            expect_v("mid_busy", K_BUSY1, 16'd1);
            step();
        end
        expect_v("mid_busy4", K_BUSY1, 16'd1);
        reset = 1;
        step();
        reset = 0;
        expect_v("abort_busy", K_BUSY1, 16'd0);
        expect_v("abort_done", K_DONE1, 16'd0);
        step();
        expect_v("abort_done2", K_DONE1, 16'd0);
        expect_v("abort_count", K_DCNT1, 16'd3);
        step();
        for (int i = 0; i < 8; i++) rdreg1("abort_zero", 3'(i), 8'h00);

        // ZERO_R0, 16-bit, three slots
        load2(3'd0, 16'hBEEF);
        a2 = 3'd0;
        expect_v("z_r0", K_A2, 16'h0000);
        step();
        load2(3'd5, 16'hBEEF);
        b2 = 3'd5;
        expect_v("z_r5", K_B2, 16'hBEEF);
        step();
        sv2 = 1; slot2 = 2'd3;
        step();
        sv2 = 0;
        expect_v("bad_slot", K_BUSY2, 16'd0);
        step();
        sv2 = 1; slot2 = 2'd2;
        step();
        sv2 = 0;
        expect_v("slot2_busy", K_BUSY2, 16'd1);
        step();
        repeat (8) step();
        load2(3'd5, 16'h1234);
        rs2 = 1; slot2 = 2'd2;
        step();
        rs2 = 0;
        repeat (9) step();
        a2 = 3'd5; b2 = 3'd0;
        expect_v("z_rest_r5", K_A2, 16'hBEEF);
        expect_v("z_rest_r0", K_B2, 16'h0000);
        step();

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
